incr_checker: RTL and testbench

INCR_CHECKER -- requirements
Module: incr_checker

---
 rtl/incr_checker.sv | 121 ++++++++++++
 tb/tb_incr_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/incr_checker.sv
// Lock detector for an 8-bit incrementing-counter stream: hunts for the sequence,
// locks after LOCK_N consecutive in-order samples, and counts breaks seen while locked.
module incr_checker #(
    parameter int LOCK_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] __in0,
    input  logic       __in1,
    output logic       __out0,
    output logic [7:0] __out1,
    output logic [7:0] __out2,
    output logic       __out3
);

    // state | meaning
    // HUNT  | no reference yet; next valid sample seeds the expected value
    // TRACK | following the stream, counting consecutive matches in mcnt
    // LOCK  | LOCK_N matches seen; a mismatch is an error and drops to TRACK
    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_N_C = 3'(LOCK_N);

    state_t     state_q, state_d;
    logic [2:0] mcnt_q, mcnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] errcnt_q, errcnt_d;
    logic       err_q, err_d;
    logic       lock_q, lock_d;

    logic [7:0] in_plus1;
    logic [7:0] exp_plus1;
    logic [2:0] mcnt_plus1;
    logic       match;

    always_comb begin
        in_plus1   = __in0 + 8'd1;
        exp_plus1  = exp_q + 8'd1;
        mcnt_plus1 = mcnt_q + 3'd1;
        match      = (__in0 == exp_q);
    end

    always_comb begin
        state_d  = state_q;
        mcnt_d   = mcnt_q;
        exp_d    = exp_q;
        errcnt_d = errcnt_q;
        err_d    = 1'b0;

        if (__in1) begin
            case (state_q)
                ST_HUNT: begin
                    exp_d   = in_plus1;
                    mcnt_d  = 3'd0;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (match) begin
                        exp_d  = exp_plus1;
                        mcnt_d = mcnt_plus1;
                        if (mcnt_plus1 == LOCK_N_C) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        exp_d  = in_plus1;
                        mcnt_d = 3'd0;
                    end
                end
                ST_LOCK: begin
                    if (match) begin
                        exp_d = exp_plus1;
                    end else begin
                        // error counter saturates so a long outage cannot wrap it back to small values
                        err_d   = 1'b1;
                        if (errcnt_q != 8'hFF) begin
                            errcnt_d = errcnt_q + 8'd1;
                        end
                        exp_d   = in_plus1;
                        mcnt_d  = 3'd0;
                        state_d = ST_TRACK;
                    end
                end
                default: begin
                    exp_d   = 8'h00;
                    mcnt_d  = 3'd0;
                    state_d = ST_HUNT;
                end
            endcase
        end

        lock_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            mcnt_q   <= 3'd0;
            exp_q    <= 8'h00;
            errcnt_q <= 8'h00;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcnt_q   <= mcnt_d;
            exp_q    <= exp_d;
            errcnt_q <= errcnt_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
        end
    end

    assign __out0 = lock_q;
    assign __out1 = errcnt_q;
    assign __out2 = exp_q;
    assign __out3 = err_q;

endmodule

// File: tb/tb_incr_checker.sv
// Scoreboarded bench for incr_checker: directed stream scenarios plus random traffic
// compared against a sequence-level reference model.
module tb_incr_checker;

    localparam int LOCK_N = 3;

    logic       clk;
    logic       rst;
    logic [7:0] in0;
    logic       in1;
    logic       out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic       out3;

    incr_checker #(.LOCK_N(LOCK_N)) dut (
        .clk    (clk),
        .rst    (rst),
        .__in0  (in0),
        .__in1  (in1),
        .__out0 (out0),
        .__out1 (out1),
        .__out2 (out2),
        .__out3 (out3)
    );

    typedef struct packed {
        logic       lock;
        logic [7:0] errs;
        logic [7:0] nxt;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    bit m_hunting;
    bit m_locked;
    int m_run;
    int m_exp;
    int m_errs;
    bit m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_hunting = 1'b1;
        m_locked  = 1'b0;
        m_run     = 0;
        m_exp     = 0;
        m_errs    = 0;
        m_err     = 1'b0;
    endtask

    // The stream is "in sequence" when each sample is the previous one plus 1 mod 256.
    task automatic model_apply(input bit v, input int d);
        m_err = 1'b0;
        if (!v) return;
        if (m_hunting) begin
            m_hunting = 1'b0;
            m_run     = 0;
            m_exp     = (d + 1) % 256;
        end else if (d == m_exp) begin
            m_exp = (m_exp + 1) % 256;
            if (!m_locked) begin
                m_run++;
                if (m_run == LOCK_N) m_locked = 1'b1;
            end
        end else begin
            if (m_locked) begin
                m_err    = 1'b1;
                m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
                m_locked = 1'b0;
            end
            m_run = 0;
            m_exp = (d + 1) % 256;
        end
    endtask

    task automatic step(input bit v, input int d);
        exp_t e;
        @(negedge clk);
        in1 = v;
        in0 = 8'(d);
        model_apply(v, d);
        e.lock = m_locked;
        e.errs = 8'(m_errs);
        e.nxt  = 8'(m_exp);
        e.err  = m_err;
        sb.push_back(e);
    endtask

    task automatic lock_up();
        for (int i = 0; i < 16 && !m_locked; i++) step(1'b1, m_exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lock"}, int'(out0), 0);
        check({tag, "_errs"}, int'(out1), 0);
        check({tag, "_nxt"},  int'(out2), 0);
        check({tag, "_err"},  int'(out3), 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("locked", int'(out0), int'(e.lock));
            check("errcnt", int'(out1), int'(e.errs));
            check("expnext", int'(out2), int'(e.nxt));
            check("errpulse", int'(out3), int'(e.err));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in1 = 1'b0;
        in0 = 8'h00;
        model_reset();
        #2;
        check_reset_outputs("por");
        #10 rst = 1'b0;

        // acquire: 10,11,12,13 locks on the last edge with next expected 14
        for (int d = 10; d <= 13; d++) step(1'b1, d);

        // wrap-around while locked: ..., FE, FF, 00, 01
        for (int d = 14; d <= 257; d++) step(1'b1, d % 256);

        // break lock at expected 20 with sample 25
        for (int d = 2; d <= 19; d++) step(1'b1, d);
        step(1'b1, 25);

        // relock, reach expected 40, idle 10 cycles, then resume with 40
        lock_up();
        while (m_exp != 40) step(1'b1, m_exp);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, 255));
        step(1'b1, 40);

        // repeated value while locked is an error
        step(1'b1, 41);
        step(1'b1, 41);

        // random traffic mixing matches, repeats, gaps and garbage
        for (int i = 0; i < 400; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 9);
            d = (r < 7) ? m_exp : (r < 8) ? (m_exp + 255) % 256 : $urandom_range(0, 255);
            step($urandom_range(0, 9) < 7, d);
        end

        // drive the error counter into saturation, then one more error
        for (int i = 0; i < 300 && m_errs < 255; i++) begin
            lock_up();
            step(1'b1, (m_exp + 5) % 256);
        end
        lock_up();
        step(1'b1, (m_exp + 9) % 256);
        check("sat_model", m_errs, 255);

        // asynchronous reset between edges while locked
        lock_up();
        step(1'b0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        #1 rst = 1'b0;
        model_reset();
        step(1'b1, 7);
        step(1'b1, 8);
        step(1'b0, 0);

        @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
